// File: rtl/alu_log_pkg.sv
// Shared types for the ALU result logger: FSM states, sample layout and defaults.
package alu_log_pkg;

  localparam int DEFAULT_DATA_W = 7;
  localparam int DEFAULT_DEPTH  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DRAIN
  } state_t;

  // One captured observation, flag in the MSB as presented on out_data.
  typedef struct packed {
    logic                      flag;
    logic [DEFAULT_DATA_W-1:0] result;
  } sample_t;

endpackage

// File: rtl/alu_log_mem.sv
// Capture buffer: DEPTH x WIDTH register array, synchronous write, combinational read.
module alu_log_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write one sample per cycle when enabled.
  // NOTE: storage has no reset; contents are only read after a full capture has written every slot.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_logger.sv
// Triggered capture buffer for the ALU {flag, result} stream.
// Arm -> wait for a flagged sample -> capture DEPTH valid samples -> drain over valid/ready.
// Optional statistics (trig_count, max_result) are built when ALU_LOG_STATS_EN is defined.
module alu_result_logger
  import alu_log_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_flag,
  output logic              out_valid,
  output logic [DATA_W:0]   out_data,
  input  logic              out_ready,
`ifdef ALU_LOG_STATS_EN
  output logic [7:0]        trig_count,
  output logic [DATA_W-1:0] max_result,
`endif
  output logic              busy,
  output logic              done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  state_t          state;
  logic [CW-1:0]   count;
  logic [CW-1:0]   rd_ptr;
  logic [DATA_W:0] rd_data;
  logic            trigger;
  logic            take_sample;

  // A flagged sample while armed starts the capture; abort suppresses any write that cycle.
  assign trigger     = (state == ARMED) && in_valid && in_flag && !abort;
  assign take_sample = trigger || ((state == CAPTURE) && in_valid && !abort);

  alu_log_mem #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + 1),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (take_sample),
    .waddr (count[AW-1:0]),
    .wdata ({in_flag, in_result}),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );

  // Buffer contents are undefined outside DRAIN, so the port shows zero there.
  assign out_data = out_valid ? rd_data : '0;

  // Capture/drain sequencer with registered busy, out_valid and done.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      rd_ptr    <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        count     <= '0;
        rd_ptr    <= '0;
        busy      <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (arm) begin
              state <= ARMED;
              busy  <= 1'b1;
              count <= '0;
            end
          end
          ARMED: begin
            if (trigger) begin
              state <= CAPTURE;
              count <= CW'(1);
            end
          end
          CAPTURE: begin
            if (in_valid) begin
              count <= count + CW'(1);
              if (count == CW'(DEPTH - 1)) begin
                state     <= DRAIN;
                rd_ptr    <= '0;
                out_valid <= 1'b1;
              end
            end
          end
          DRAIN: begin
            if (out_ready) begin
              rd_ptr <= rd_ptr + CW'(1);
              if (rd_ptr == CW'(DEPTH - 1)) begin
                state     <= IDLE;
                busy      <= 1'b0;
                out_valid <= 1'b0;
                done      <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef ALU_LOG_STATS_EN
  // Trigger counter (saturating) and running maximum of samples written in this capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig_count <= '0;
      max_result <= '0;
    end else begin
      if ((state == IDLE) && arm && !abort) begin
        max_result <= '0;
      end else if (take_sample && (in_result > max_result)) begin
        max_result <= in_result;
      end
      if (trigger && (trig_count != 8'hFF)) begin
        trig_count <= trig_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_logger.sv
// Self-checking bench for alu_result_logger: directed and randomized captures against
// a queue-based model of which samples must come out, in order, after each trigger.
module tb_alu_result_logger;
  import alu_log_pkg::*;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 7;

  logic              clk = 1'b0;
  logic              reset;
  logic              arm, abort, in_valid, in_flag, out_ready;
  logic [DATA_W-1:0] in_result;
  logic              out_valid, busy, done;
  logic [DATA_W:0]   out_data;
`ifdef ALU_LOG_STATS_EN
  logic [7:0]        trig_count;
  logic [DATA_W-1:0] max_result;
`endif

  always #5 clk = ~clk;

  alu_result_logger #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_result  (in_result),
    .in_flag    (in_flag),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
`ifdef ALU_LOG_STATS_EN
    .trig_count (trig_count),
    .max_result (max_result),
`endif
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    bit             v;
    bit             f;
    bit [DATA_W-1:0] r;
  } stim_t;

  int      total = 0;
  int      bad   = 0;
  int      trig_model = 0;
  stim_t   stim_q[$];
  sample_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    arm       = 1'b0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_flag   = 1'b0;
    in_result = '0;
    out_ready = 1'b0;
  endtask

  task automatic random_sample();
    in_valid  = 1'($urandom);
    in_flag   = 1'($urandom);
    in_result = DATA_W'($urandom);
  endtask

  // Next stream item: queued directed stimulus first, random afterwards.
  task automatic drive_stim(output stim_t s);
    if (stim_q.size() > 0) begin
      s = stim_q.pop_front();
    end else begin
      s.v = ($urandom_range(0, 3) != 0);
      s.f = ($urandom_range(0, 3) == 0);
      s.r = DATA_W'($urandom);
    end
    in_valid  = s.v;
    in_flag   = s.f;
    in_result = s.r;
  endtask

  task automatic push_stim(input bit v, input bit f, input int r);
    stim_t s;
    s.v = v;
    s.f = f;
    s.r = DATA_W'(r);
    stim_q.push_back(s);
  endtask

  // ready_mode: 0 always ready, 1 toggling, 2 random.
  // abort_at > 0 aborts once that many samples are captured.
  task automatic run_capture(input int ready_mode, input bit arm_in_drain, input int abort_at);
    stim_t s;
    bit    triggered = 1'b0;
    int    max_seen  = 0;
    int    cyc       = 0;
    int    accepts   = 0;
    bit    rdy;
    exp_q.delete();

    arm = 1'b1;
    in_valid = 1'b0;
    step();
    arm = 1'b0;
    check("arm_busy", busy, 1);
    check("arm_out_valid", out_valid, 0);

    while (exp_q.size() < DEPTH && cyc < 300) begin
      if (abort_at > 0 && exp_q.size() == abort_at) begin
        abort = 1'b1;
        random_sample();
        step();
        idle_inputs();
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_done", done, 0);
        for (int i = 0; i < 3; i++) begin
          random_sample();
          step();
          check("post_abort_out_valid", out_valid, 0);
          check("post_abort_done", done, 0);
          check("post_abort_busy", busy, 0);
        end
        idle_inputs();
        stim_q.delete();
        return;
      end
      drive_stim(s);
      check("cap_busy", busy, 1);
      check("cap_out_valid", out_valid, 0);
      step();
      cyc++;
      if (s.v && (triggered || s.f)) begin
        if (!triggered) trig_model++;
        triggered = 1'b1;
        exp_q.push_back('{flag: s.f, result: s.r});
        if (int'(s.r) > max_seen) max_seen = int'(s.r);
      end
    end
    stim_q.delete();
    if (exp_q.size() < DEPTH) begin
      check("capture_timeout", exp_q.size(), DEPTH);
      idle_inputs();
      return;
    end

    cyc = 0;
    while (accepts < DEPTH && cyc < 200) begin
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = cyc[0];
        default: rdy = 1'($urandom);
      endcase
      out_ready = rdy;
      arm = arm_in_drain ? 1'($urandom) : 1'b0;
      random_sample();
      check("drain_out_valid", out_valid, 1);
      check("drain_data", out_data, exp_q[0]);
      check("drain_busy", busy, 1);
      check("drain_done", done, 0);
      step();
      if (rdy) begin
        void'(exp_q.pop_front());
        accepts++;
      end
      cyc++;
    end
    idle_inputs();
    if (accepts < DEPTH) begin
      check("drain_timeout", accepts, DEPTH);
      return;
    end
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    check("end_out_valid", out_valid, 0);
`ifdef ALU_LOG_STATS_EN
    check("max_result", max_result, max_seen);
    check("trig_count", trig_count, trig_model);
`endif
    step();
    check("done_once", done, 0);
    check("arm_not_queued", busy, 0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;

    // Reset held with random inputs: every output stays zero.
    for (int i = 0; i < 4; i++) begin
      arm   = 1'($urandom);
      abort = 1'($urandom);
      random_sample();
      out_ready = 1'($urandom);
      step();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
`ifdef ALU_LOG_STATS_EN
      check("rst_trig_count", trig_count, 0);
      check("rst_max_result", max_result, 0);
`endif
    end
    idle_inputs();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      random_sample();
      out_ready = 1'($urandom);
      step();
      check("idle_busy", busy, 0);
      check("idle_out_valid", out_valid, 0);
    end
    idle_inputs();

    // Basic capture: trigger on result 9, expect 9..16.
    push_stim(1, 0, 3);
    push_stim(1, 0, 5);
    push_stim(1, 1, 9);
    for (int r = 10; r <= 16; r++) push_stim(1, 0, r);
    run_capture(0, 1'b0, 0);

    // Pre-trigger samples and bubbles; an invalid flagged sample must not trigger.
    push_stim(1, 0, 1);
    push_stim(1, 0, 2);
    push_stim(0, 1, 50);
    push_stim(1, 0, 3);
    push_stim(1, 1, 20);
    for (int r = 21; r <= 27; r++) begin
      push_stim(0, 1, 99);
      push_stim(1, r[0], r);
    end
    run_capture(2, 1'b0, 0);

    // Backpressure with a toggling ready and stray arm pulses during drain.
    run_capture(1, 1'b1, 0);

    // Abort once four samples are captured.
    push_stim(1, 1, 40);
    run_capture(0, 1'b0, 4);

    // arm together with abort in IDLE stays idle.
    arm = 1'b1;
    abort = 1'b1;
    step();
    idle_inputs();
    check("arm_abort_busy", busy, 0);
    step();
    check("arm_abort_busy_hold", busy, 0);
    check("arm_abort_out_valid", out_valid, 0);

    // Two captures peaking at 100 then 42; the ignored pre-trigger 127 must not count.
    push_stim(1, 0, 127);
    push_stim(1, 1, 100);
    for (int r = 1; r <= 7; r++) push_stim(1, 0, r);
    run_capture(0, 1'b0, 0);
    push_stim(1, 1, 42);
    for (int r = 10; r <= 16; r++) push_stim(1, r[0], r);
    run_capture(2, 1'b0, 0);

    // Random captures.
    for (int k = 0; k < 6; k++) begin
      run_capture($urandom_range(0, 2), 1'($urandom), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
